// File: rtl/addsub_pkg.sv
// Shared types and constants for the multi-cycle adder/subtractor.
// Holds the FSM encoding, default sizes and the WIDTH/CHUNK legality check.
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_CHUNK = 4;

   // WIDTH must split into whole chunks
   function automatic bit chunk_ok(int w, int c);
      return (c > 0) && (w >= c) && ((w % c) == 0);
   endfunction

endpackage

// File: rtl/multicycle_addsub_chunk_adder.sv
// CHUNK-bit ripple adder built from full-adder cells.
// Ports: a, b, cin in; s, cout out. Purely combinational.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module chunk_adder #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout
);
   logic [CHUNK:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      fa_cell u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (c[i]),
         .s    (s[i]),
         .cout (c[i+1])
      );
   end

   assign cout = c[CHUNK];
endmodule

// File: rtl/multicycle_addsub.sv
// Multi-cycle WIDTH-bit add/sub, CHUNK bits per clock through one adder.
// Ports: clock, reset, start, sub, a, b in; busy, done, s, cout, ovf out.
module multicycle_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);
   localparam int N  = WIDTH / CHUNK;
   localparam int KW = (N > 1) ? $clog2(N) : 1;

   if (!chunk_ok(WIDTH, CHUNK)) begin : g_bad_cfg
      $error("multicycle_addsub: WIDTH must be a multiple of CHUNK");
   end

   state_e           state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [CHUNK-1:0] ca_a, ca_b, ca_s;
   logic             ca_co;
   logic             last;

   // b_q already holds B' (inverted for subtract)
   assign ca_a = a_q[int'(k_q)*CHUNK +: CHUNK];
   assign ca_b = b_q[int'(k_q)*CHUNK +: CHUNK];
   assign last = (k_q == KW'(N-1));

   chunk_adder #(.CHUNK(CHUNK)) u_add (
      .a    (ca_a),
      .b    (ca_b),
      .cin  (carry_q),
      .s    (ca_s),
      .cout (ca_co)
   );

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d     = a;
               b_d     = b ^ {WIDTH{sub}};
               carry_d = sub;
               k_d     = '0;
               s_d     = '0;
               cout_d  = 1'b0;
               ovf_d   = 1'b0;
               state_d = RUN;
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         RUN: begin
            s_d[int'(k_q)*CHUNK +: CHUNK] = ca_s;
            carry_d = ca_co;
            k_d     = k_q + 1'b1;
            if (last) begin
               cout_d  = ca_co;
               // operands agree in sign but sum does not
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1])
                      && (ca_s[CHUNK-1] != a_q[WIDTH-1]);
               k_d     = '0;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         k_q     <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign s    = s_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_multicycle_addsub.sv
// Directed bench for multicycle_addsub: default 16/4 plus 8/2 and 16/16.
// Each check is an immediate assertion against hand-computed values.
module tb_multicycle_addsub;

   logic clock = 1'b0;
   logic reset = 1'b1;

   always #5 clock = ~clock;

   // 16/4 instance
   logic        st = 0, sb = 0;
   logic [15:0] av = 0, bv = 0;
   logic        bsy, dn, co, ov;
   logic [15:0] sv;

   multicycle_addsub #(.WIDTH(16), .CHUNK(4)) dut (
      .clock (clock), .reset (reset), .start (st), .sub (sb),
      .a (av), .b (bv), .busy (bsy), .done (dn),
      .s (sv), .cout (co), .ovf (ov)
   );

   // 8/2 instance
   logic       st8 = 0, sb8 = 0;
   logic [7:0] a8 = 0, b8 = 0;
   logic       bsy8, dn8, co8, ov8;
   logic [7:0] s8;

   multicycle_addsub #(.WIDTH(8), .CHUNK(2)) dut8 (
      .clock (clock), .reset (reset), .start (st8), .sub (sb8),
      .a (a8), .b (b8), .busy (bsy8), .done (dn8),
      .s (s8), .cout (co8), .ovf (ov8)
   );

   // 16/16 instance
   logic        st1 = 0, sb1 = 0;
   logic [15:0] a1 = 0, b1 = 0;
   logic        bsy1, dn1, co1, ov1;
   logic [15:0] s1;

   multicycle_addsub #(.WIDTH(16), .CHUNK(16)) dut1 (
      .clock (clock), .reset (reset), .start (st1), .sub (sb1),
      .a (a1), .b (b1), .busy (bsy1), .done (dn1),
      .s (s1), .cout (co1), .ovf (ov1)
   );

   int total  = 0;
   int passed = 0;
   int fails  = 0;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // launch on the main instance, return busy cycles seen until done
   task automatic do_op(input logic [15:0] x, input logic [15:0] y,
                        input logic m, output int nb);
      st = 1; av = x; bv = y; sb = m;
      step();
      st = 0; av = 16'hDEAD; bv = 16'hBEEF; sb = ~m;
      nb = 0;
      while (!dn && nb < 20) begin
         if (bsy) nb++;
         step();
      end
   endtask

   task automatic chk_res(input string tag, input logic [15:0] es,
                          input logic ec, input logic eo);
      chk({tag, ".done"}, {31'd0, dn}, 32'd1);
      chk({tag, ".s"}, {16'd0, sv}, {16'd0, es});
      chk({tag, ".cout"}, {31'd0, co}, {31'd0, ec});
      chk({tag, ".ovf"}, {31'd0, ov}, {31'd0, eo});
   endtask

   initial begin
      int nb;
      int ne;
      #2;
      chk("rst.busy", {31'd0, bsy}, 32'd0);
      chk("rst.done", {31'd0, dn}, 32'd0);
      chk("rst.s", {16'd0, sv}, 32'd0);
      step();
      reset = 0;
      step();

      do_op(16'h1234, 16'h0FFF, 1'b0, nb);
      chk("t1.busycyc", nb, 4);
      chk_res("t1", 16'h2233, 1'b0, 1'b0);
      step();
      chk("t1.pulse", {31'd0, dn}, 32'd0);
      chk("t1.hold", {16'd0, sv}, 32'h2233);

      do_op(16'hFFFF, 16'h0001, 1'b0, nb);
      chk_res("t2", 16'h0000, 1'b1, 1'b0);
      step();
      do_op(16'h7FFF, 16'h0001, 1'b0, nb);
      chk_res("t3", 16'h8000, 1'b0, 1'b1);
      step();

      do_op(16'h0005, 16'h0007, 1'b1, nb);
      chk_res("sub1", 16'hFFFE, 1'b0, 1'b0);
      step();
      do_op(16'h8000, 16'h0001, 1'b1, nb);
      chk_res("sub2", 16'h7FFF, 1'b1, 1'b1);
      step();

      // start during RUN must be ignored
      st = 1; av = 16'h0001; bv = 16'h0001; sb = 0;
      step();
      chk("ign.clr", {16'd0, sv}, 32'd0);
      st = 0;
      step();
      st = 1; av = 16'hAAAA; bv = 16'h5555;
      step();
      st = 0;
      ne = 0;
      while (!dn && ne < 20) begin
         ne++;
         step();
      end
      chk_res("ign", 16'h0002, 1'b0, 1'b0);

      // back-to-back start in the done cycle
      st = 1; av = 16'h0003; bv = 16'h0004;
      step();
      st = 0;
      chk("b2b.busy", {31'd0, bsy}, 32'd1);
      chk("b2b.clr", {16'd0, sv}, 32'd0);
      ne = 1;
      while (!dn && ne < 20) begin
         ne++;
         step();
      end
      chk("b2b.edges", ne, 5);
      chk_res("b2b", 16'h0007, 1'b0, 1'b0);
      step();

      // async reset mid-operation
      st = 1; av = 16'h1111; bv = 16'h1111;
      step();
      st = 0;
      step();
      step();
      #2 reset = 1;
      #1;
      chk("ar.busy", {31'd0, bsy}, 32'd0);
      chk("ar.done", {31'd0, dn}, 32'd0);
      chk("ar.s", {16'd0, sv}, 32'd0);
      chk("ar.cout", {31'd0, co}, 32'd0);
      step();
      reset = 0;
      step();
      chk("ar.nodone", {31'd0, dn}, 32'd0);
      chk("ar.idle", {31'd0, bsy}, 32'd0);
      do_op(16'h0010, 16'h0020, 1'b0, nb);
      chk_res("ar2", 16'h0030, 1'b0, 1'b0);
      step();

      // 8-bit, 2-bit chunks
      st8 = 1; a8 = 8'hFF; b8 = 8'h01;
      step();
      st8 = 0;
      nb = 0;
      while (!dn8 && nb < 20) begin
         if (bsy8) nb++;
         step();
      end
      chk("w8.busycyc", nb, 4);
      chk("w8.done", {31'd0, dn8}, 32'd1);
      chk("w8.s", {24'd0, s8}, 32'h00);
      chk("w8.cout", {31'd0, co8}, 32'd1);
      chk("w8.ovf", {31'd0, ov8}, 32'd0);

      // single-chunk configuration
      st1 = 1; a1 = 16'h1234; b1 = 16'h0FFF;
      step();
      st1 = 0;
      chk("w16.busy", {31'd0, bsy1}, 32'd1);
      step();
      chk("w16.done", {31'd0, dn1}, 32'd1);
      chk("w16.nobusy", {31'd0, bsy1}, 32'd0);
      chk("w16.s", {16'd0, s1}, 32'h2233);
      chk("w16.cout", {31'd0, co1}, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
